// File: rtl/dimm_pkg.sv
// Shared command/bank-state types and the CA command decoder for the DDR4 DIMM model.
package dimm_pkg;

    typedef enum logic [2:0] {
        CMD_ACT,
        CMD_REF,
        CMD_PRE,
        CMD_WR,
        CMD_RD,
        CMD_NOP
    } cmd_e;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_ACTIVATING,
        BS_ACTIVE,
        BS_REFRESHING
    } bank_state_e;

    // rcw is {A16, A15, A14} = {RAS_n, CAS_n, WE_n}
    function automatic cmd_e decode_cmd(input logic act_n, input logic [2:0] rcw);
        cmd_e cmd;
        cmd = CMD_NOP;
        if (!act_n) begin
            cmd = CMD_ACT;
        end else begin
            case (rcw)
                3'b001:  cmd = CMD_REF;
                3'b010:  cmd = CMD_PRE;
                3'b100:  cmd = CMD_WR;
                3'b101:  cmd = CMD_RD;
                default: cmd = CMD_NOP;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ddr4_dimm_model_if.sv
// Command/address bus, per-bank sync flags and status outputs of the DDR4 DIMM model.
interface ddr4_dimm_model_if #(
    parameter int unsigned RANKS     = 1,
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned ADDRWIDTH = 17
);
    localparam int unsigned BANKGROUPS    = 1 << BGWIDTH;
    localparam int unsigned BANKSPERGROUP = 1 << BAWIDTH;

    logic                                          cke;
    logic [RANKS-1:0]                              cs_n;
    logic                                          act_n;
    logic [ADDRWIDTH-1:0]                          A;
    logic [BGWIDTH-1:0]                            bg;
    logic [BAWIDTH-1:0]                            ba;
    logic                                          odt;
    logic                                          parity;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]      sync;
    logic                                          alert_n;
    logic [BANKGROUPS*BANKSPERGROUP-1:0]           bank_busy;

    modport master (
        output cke, cs_n, act_n, A, bg, ba, odt, parity, sync,
        input  alert_n, bank_busy
    );

    modport slave (
        input  cke, cs_n, act_n, A, bg, ba, odt, parity, sync,
        output alert_n, bank_busy
    );

endinterface

// File: rtl/dimm_bank_fsm.sv
// Per-bank state machine: IDLE/ACTIVATING/ACTIVE/REFRESHING with the tRFC busy counter.
module dimm_bank_fsm
    import dimm_pkg::*;
#(
    parameter int unsigned TRFC = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  cmd_e        cmd,
    input  logic        hit,
    input  logic        sync,
    output bank_state_e state,
    output logic        busy
);
    localparam int unsigned RW = (TRFC > 1) ? $clog2(TRFC) : 1;

    bank_state_e   state_nxt;
    logic [RW-1:0] rfc_cnt;
    logic [RW-1:0] rfc_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BS_IDLE;
            rfc_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rfc_cnt <= rfc_cnt_nxt;
            busy    <= (state_nxt != BS_IDLE);
        end
    end

    // Commands that are illegal in the current state simply leave it unchanged.
    always_comb begin
        state_nxt   = state;
        rfc_cnt_nxt = rfc_cnt;
        case (state)
            BS_IDLE: begin
                if (hit && cmd == CMD_ACT) begin
                    state_nxt = BS_ACTIVATING;
                end else if (hit && cmd == CMD_REF) begin
                    state_nxt   = BS_REFRESHING;
                    rfc_cnt_nxt = RW'(TRFC - 1);
                end
            end
            BS_ACTIVATING: begin
                if (hit && cmd == CMD_PRE) begin
                    state_nxt = BS_IDLE;
                end else if (sync) begin
                    state_nxt = BS_ACTIVE;
                end
            end
            BS_ACTIVE: begin
                if (hit && cmd == CMD_PRE) begin
                    state_nxt = BS_IDLE;
                end
            end
            BS_REFRESHING: begin
                if (rfc_cnt == '0) begin
                    state_nxt = BS_IDLE;
                end else begin
                    rfc_cnt_nxt = rfc_cnt - RW'(1);
                end
            end
            default: state_nxt = BS_IDLE;
        endcase
    end

endmodule

// File: rtl/ddr4_dimm_model.sv
// Cycle-level one-rank DDR4 RDIMM emulation model: CA decode, per-bank FSMs, burst pipeline, data cache.
// Optional CA parity checking is enabled by defining DIMM_CA_PARITY_EN.
module ddr4_dimm_model
    import dimm_pkg::*;
#(
    parameter int unsigned RANKS        = 1,
    parameter int unsigned CHIPS        = 18,
    parameter int unsigned BGWIDTH      = 2,
    parameter int unsigned BAWIDTH      = 2,
    parameter int unsigned ADDRWIDTH    = 17,
    parameter int unsigned COLWIDTH     = 10,
    parameter int unsigned DEVICE_WIDTH = 4,
    parameter int unsigned BL           = 8,
    parameter int unsigned CHWIDTH      = 5,
    parameter int unsigned CL           = 11,
    parameter int unsigned CWL          = 9,
    parameter int unsigned TRFC         = 20
) (
    input  logic                             ck_t,
    input  logic                             reset_n,
    input  logic                             ck_c,
    ddr4_dimm_model_if.slave                 bus,
    inout  wire  [DEVICE_WIDTH*CHIPS-1:0]    dq,
    inout  wire  [CHIPS-1:0]                 dqs_t,
    inout  wire  [CHIPS-1:0]                 dqs_c
);
    localparam int unsigned DQWIDTH       = DEVICE_WIDTH * CHIPS;
    localparam int unsigned BANKGROUPS    = 1 << BGWIDTH;
    localparam int unsigned BANKSPERGROUP = 1 << BAWIDTH;
    localparam int unsigned NBANK         = BANKGROUPS * BANKSPERGROUP;
    localparam int unsigned BANKW         = BGWIDTH + BAWIDTH;
    localparam int unsigned BEATW         = $clog2(BL);
    localparam int unsigned CACHE_AW      = BANKW + CHWIDTH + BEATW;
    localparam int unsigned MAXLAT        = (CL > CWL) ? CL : CWL;
    localparam int unsigned CNTW          = $clog2(MAXLAT + BL + 1);

    // Command decode
    cmd_e                 cmd_c;
    logic                 cmd_valid_c;
    logic                 par_ok_c;
    logic                 pre_all_c;
    logic [BANKW-1:0]     sel_c;
    logic [COLWIDTH-1:0]  col_c;

    assign cmd_valid_c = bus.cke & ~(&bus.cs_n);
    assign sel_c       = {bus.bg, bus.ba};
    assign col_c       = bus.A[COLWIDTH-1:0];

`ifdef DIMM_CA_PARITY_EN
    assign par_ok_c = ~(^{bus.act_n, bus.A, bus.bg, bus.ba, bus.parity});
`else
    assign par_ok_c = 1'b1;
`endif

    assign cmd_c     = (cmd_valid_c && par_ok_c) ? decode_cmd(bus.act_n, bus.A[ADDRWIDTH-1 -: 3]) : CMD_NOP;
    assign pre_all_c = (cmd_c == CMD_PRE) && bus.A[10];

    // Per-bank state machines; bank index is {bg, ba}
    bank_state_e      bank_state [NBANK];
    logic [NBANK-1:0] busy_vec;

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
            localparam int unsigned K = g * BANKSPERGROUP + b;
            dimm_bank_fsm #(
                .TRFC (TRFC)
            ) u_fsm (
                .clk   (ck_t),
                .rst_n (reset_n),
                .cmd   (cmd_c),
                .hit   (pre_all_c || (sel_c == BANKW'(K))),
                .sync  (bus.sync[g][b]),
                .state (bank_state[K]),
                .busy  (busy_vec[K])
            );
        end
    end

    // Open row per bank, captured on an accepted ACT
    logic [ADDRWIDTH-1:0] open_row [NBANK];

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBANK; i++) begin
                open_row[i] <= '0;
            end
        end else if (cmd_c == CMD_ACT && bank_state[sel_c] == BS_IDLE) begin
            open_row[sel_c] <= bus.A;
        end
    end

    // Single in-flight column burst: cnt counts edges since the RD/WR was accepted
    logic                  burst_active;
    logic                  burst_rd;
    logic [CNTW-1:0]       burst_cnt;
    logic [BANKW-1:0]      burst_bank;
    logic [CHWIDTH-1:0]    burst_idx;
    logic [CNTW-1:0]       cnt_nxt_c;
    logic [CNTW-1:0]       lat_c;
    logic                  last_c;
    logic                  in_beats_c;
    logic                  rd_beat_c;
    logic                  wr_beat_c;
    logic                  rdwr_c;
    logic [BEATW-1:0]      beat_c;
    logic [CACHE_AW-1:0]   cache_addr_c;

    assign rdwr_c       = ((cmd_c == CMD_RD) || (cmd_c == CMD_WR)) &&
                          (bank_state[sel_c] == BS_ACTIVE) && !burst_active;
    assign cnt_nxt_c    = burst_cnt + CNTW'(1);
    assign lat_c        = burst_rd ? CNTW'(CL) : CNTW'(CWL);
    assign last_c       = (cnt_nxt_c == lat_c + CNTW'(BL - 1));
    assign in_beats_c   = burst_active && (cnt_nxt_c >= lat_c) && (cnt_nxt_c <= lat_c + CNTW'(BL - 1));
    assign rd_beat_c    = in_beats_c && burst_rd;
    assign wr_beat_c    = in_beats_c && !burst_rd;
    assign beat_c       = BEATW'(cnt_nxt_c - lat_c);
    assign cache_addr_c = {burst_bank, burst_idx, beat_c};

    logic                  out_oe;
    logic [DQWIDTH-1:0]    out_data;
    logic [CHIPS-1:0]      out_dqs;

    // Burst data store; deliberately not reset so contents survive a DIMM reset.
    logic [DQWIDTH-1:0] cache [1 << CACHE_AW];

    always_ff @(posedge ck_t) begin
        if (wr_beat_c) begin
            cache[cache_addr_c] <= dq;
        end
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            burst_active <= 1'b0;
            burst_rd     <= 1'b0;
            burst_cnt    <= '0;
            burst_bank   <= '0;
            burst_idx    <= '0;
            out_oe       <= 1'b0;
            out_data     <= '0;
            out_dqs      <= '0;
        end else begin
            if (rdwr_c) begin
                burst_active <= 1'b1;
                burst_rd     <= (cmd_c == CMD_RD);
                burst_cnt    <= '0;
                burst_bank   <= sel_c;
                burst_idx    <= col_c[CHWIDTH+2:3];
            end else if (burst_active) begin
                burst_cnt <= cnt_nxt_c;
                if (last_c) begin
                    burst_active <= 1'b0;
                end
            end
            out_oe <= rd_beat_c;
            if (rd_beat_c) begin
                out_data <= cache[cache_addr_c];
                out_dqs  <= {CHIPS{~beat_c[0]}};
            end
        end
    end

    assign dq    = out_oe ? out_data : {DQWIDTH{1'bz}};
    assign dqs_t = out_oe ? out_dqs  : {CHIPS{1'bz}};
    assign dqs_c = out_oe ? ~out_dqs : {CHIPS{1'bz}};

    // Alert is a one-cycle low pulse following a command with bad CA parity
    logic alert_q;

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            alert_q <= 1'b1;
        end else begin
`ifdef DIMM_CA_PARITY_EN
            alert_q <= ~(cmd_valid_c & ~par_ok_c);
`else
            alert_q <= 1'b1;
`endif
        end
    end

    assign bus.alert_n   = alert_q;
    assign bus.bank_busy = busy_vec;

    // Inputs and state that the model carries but never consumes
    logic [NBANK-1:0] row_par_c;

    always_comb begin
        row_par_c = '0;
        for (int i = 0; i < NBANK; i++) begin
            row_par_c[i] = ^open_row[i];
        end
    end

    wire unused_sink = ^{row_par_c, col_c, ck_c, bus.odt, bus.parity};

endmodule

// File: tb/tb_ddr4_dimm_model.sv
// Directed bench for ddr4_dimm_model: refresh sweep, bank FSM legality, WR/RD burst, gating, async reset, parity.
module tb_ddr4_dimm_model;

    localparam int CL   = 11;
    localparam int CWL  = 9;
    localparam int TRFC = 20;
    localparam int BL   = 8;

    logic ck_t = 1'b0;
    logic ck_c;
    logic reset_n;

    always #5 ck_t = ~ck_t;
    assign ck_c = ~ck_t;

    ddr4_dimm_model_if bus ();

    wire  [71:0] dq;
    wire  [17:0] dqs_t;
    wire  [17:0] dqs_c;
    logic [71:0] tb_dq;
    logic        tb_dq_oe;

    assign dq = tb_dq_oe ? tb_dq : {72{1'bz}};

    // Weak pull-ups make a released bus read as all ones
    for (genvar i = 0; i < 72; i++) begin : g_pu_dq
        pullup pu (dq[i]);
    end
    for (genvar i = 0; i < 18; i++) begin : g_pu_dqs
        pullup pu_t (dqs_t[i]);
        pullup pu_c (dqs_c[i]);
    end

    ddr4_dimm_model dut (
        .ck_t    (ck_t),
        .reset_n (reset_n),
        .ck_c    (ck_c),
        .bus     (bus),
        .dq      (dq),
        .dqs_t   (dqs_t),
        .dqs_c   (dqs_c)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [71:0] exp_q [$];
    logic [71:0] exp_v;
    logic        strobe;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.cke    = 1'b1;
        bus.cs_n   = 1'b1;
        bus.act_n  = 1'b1;
        bus.A      = '0;
        bus.bg     = '0;
        bus.ba     = '0;
        bus.parity = 1'b0;
    endtask

    // Present one command for one edge (called at a negedge), returns at the following negedge
    task automatic issue(input logic act_n, input logic [16:0] a, input logic [3:0] bank, input logic bad_par);
        bus.cs_n   = 1'b0;
        bus.act_n  = act_n;
        bus.A      = a;
        bus.bg     = bank[3:2];
        bus.ba     = bank[1:0];
        bus.parity = (^{act_n, a, bank}) ^ bad_par;
        @(negedge ck_t);
        drive_idle();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge ck_t);
    endtask

    initial begin
        reset_n  = 1'b0;
        drive_idle();
        bus.odt  = 1'b0;
        bus.sync = '0;
        tb_dq    = '0;
        tb_dq_oe = 1'b0;
        cycles(3);

        check("rst_busy",  72'(bus.bank_busy), 72'(0));
        check("rst_alert", 72'(bus.alert_n), 72'(1));
        check("rst_dq",    dq, {72{1'b1}});
        check("rst_dqs_t", 72'(dqs_t), 72'(18'h3FFFF));
        check("rst_dqs_c", 72'(dqs_c), 72'(18'h3FFFF));
        reset_n = 1'b1;
        cycles(1);

        // Refresh sweep over all 16 banks, one REF per cycle
        for (int k = 0; k < 16; k++) begin
            issue(1'b1, 17'h04001, 4'(k), 1'b0);
            check($sformatf("ref_rise%0d", k), 72'(bus.bank_busy), 72'((32'd1 << (k + 1)) - 32'd1));
        end
        cycles(4);
        check("ref_hold0",  72'(bus.bank_busy), 72'(16'hFFFF));
        cycles(1);
        check("ref_fall0",  72'(bus.bank_busy), 72'(16'hFFFE));
        cycles(14);
        check("ref_hold15", 72'(bus.bank_busy), 72'(16'h8000));
        cycles(1);
        check("ref_fall15", 72'(bus.bank_busy), 72'(0));

        // ACT bank {1,2} with sync low: activating, RD dropped
        issue(1'b0, 17'd5, 4'd6, 1'b0);
        check("act_busy", 72'(bus.bank_busy), 72'(16'h0040));
        issue(1'b1, 17'h14008, 4'd6, 1'b0);
        cycles(CL);
        check("rd_drop_dq", dq, {72{1'b1}});
        check("rd_drop_busy", 72'(bus.bank_busy), 72'(16'h0040));

        // Sync -> ACTIVE; REF to an active bank must not start a refresh
        bus.sync[1][2] = 1'b1;
        cycles(1);
        issue(1'b1, 17'h04001, 4'd6, 1'b0);
        cycles(TRFC + 1);
        check("ref_drop_busy", 72'(bus.bank_busy), 72'(16'h0040));

        // WR col 8 with beats 1..8, then RD it back through the scoreboard
        issue(1'b1, 17'h10008, 4'd6, 1'b0);
        cycles(CWL - 1);
        for (int j = 0; j < BL; j++) begin
            tb_dq    = 72'(j + 1);
            tb_dq_oe = 1'b1;
            exp_q.push_back(72'(j + 1));
            @(negedge ck_t);
        end
        tb_dq_oe = 1'b0;
        issue(1'b1, 17'h14008, 4'd6, 1'b0);
        cycles(CL - 1);
        check("rd_pre_dq", dq, {72{1'b1}});
        for (int j = 0; j < BL; j++) begin
            @(negedge ck_t);
            exp_v  = (exp_q.size() > 0) ? exp_q.pop_front() : {72{1'b1}};
            strobe = (j % 2 == 0);
            check($sformatf("rd_beat%0d", j), dq, exp_v);
            check($sformatf("rd_dqs_t%0d", j), 72'(dqs_t), 72'({18{strobe}}));
            check($sformatf("rd_dqs_c%0d", j), 72'(dqs_c), 72'({18{~strobe}}));
        end
        @(negedge ck_t);
        check("rd_post_dq",    dq, {72{1'b1}});
        check("rd_post_dqs_t", 72'(dqs_t), 72'(18'h3FFFF));
        check("sb_empty", 72'(exp_q.size()), 72'(0));

        // PRE single bank, then PRE-all (A10) closing two activating banks
        issue(1'b1, 17'h08000, 4'd6, 1'b0);
        check("pre_busy", 72'(bus.bank_busy), 72'(0));
        issue(1'b0, 17'd9, 4'd0, 1'b0);
        issue(1'b0, 17'd3, 4'd15, 1'b0);
        check("act2_busy", 72'(bus.bank_busy), 72'(16'h8001));
        issue(1'b1, 17'h08400, 4'd5, 1'b0);
        check("preall_busy", 72'(bus.bank_busy), 72'(0));

        // cke low / cs_n high: commands ignored
        bus.cke   = 1'b0;
        bus.cs_n  = 1'b0;
        bus.act_n = 1'b0;
        bus.A     = 17'd5;
        bus.bg    = 2'd0;
        bus.ba    = 2'd2;
        cycles(1);
        check("cke_gate", 72'(bus.bank_busy), 72'(0));
        bus.cke    = 1'b1;
        bus.cs_n   = 1'b1;
        bus.act_n  = 1'b1;
        bus.A      = 17'h04001;
        bus.parity = ^{1'b1, 17'h04001, 4'd2};
        cycles(1);
        check("cs_gate", 72'(bus.bank_busy), 72'(0));
        drive_idle();

        // Asynchronous reset in the middle of a read burst
        issue(1'b0, 17'd5, 4'd6, 1'b0);
        cycles(1);
        issue(1'b1, 17'h14008, 4'd6, 1'b0);
        cycles(CL + 2);
        check("mid_dq",    dq, 72'h3);
        check("mid_dqs_t", 72'(dqs_t), 72'(18'h3FFFF));
        check("mid_busy",  72'(bus.bank_busy), 72'(16'h0040));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_dq",    dq, {72{1'b1}});
        check("arst_dqs_t", 72'(dqs_t), 72'(18'h3FFFF));
        check("arst_dqs_c", 72'(dqs_c), 72'(18'h3FFFF));
        check("arst_busy",  72'(bus.bank_busy), 72'(0));
        @(negedge ck_t);
        reset_n = 1'b1;
        cycles(1);

`ifdef DIMM_CA_PARITY_EN
        issue(1'b1, 17'h04001, 4'd3, 1'b1);
        check("par_drop_busy", 72'(bus.bank_busy), 72'(0));
        check("par_alert_lo",  72'(bus.alert_n), 72'(0));
        cycles(1);
        check("par_alert_hi",  72'(bus.alert_n), 72'(1));
        issue(1'b1, 17'h04001, 4'd3, 1'b0);
        check("par_ok_busy",   72'(bus.bank_busy), 72'(16'h0008));
        check("par_ok_alert",  72'(bus.alert_n), 72'(1));
`else
        issue(1'b1, 17'h04001, 4'd3, 1'b1);
        check("nopar_busy",  72'(bus.bank_busy), 72'(16'h0008));
        check("nopar_alert", 72'(bus.alert_n), 72'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
